branch_resolve_unit: RTL and testbench



---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_fifo.sv | 56 +++++
 rtl/branch_resolve_unit.sv | 85 ++++++++
 tb/tb_branch_resolve_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor slice: counter state encoding,
// default queue depth and the saturation limit helper for statistics counters.
package bp_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_ctr_t;

    localparam int BP_DEFAULT_DEPTH = 4;

    // All-ones value of a w-bit counter, usable in constant expressions.
    function automatic logic [31:0] cnt_sat_max(input int unsigned w);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/bp_fifo.sv
// 1-bit wide in-order queue of predictions; full/empty derive from the
// occupancy counter so pointers may simply wrap modulo DEPTH.
module bp_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   din,
    input  logic                   pop,
    input  logic                   clear,
    output logic                   dout,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (occupancy == OW'(DEPTH));
    assign empty   = (occupancy == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks in-flight predictions, compares each against its resolved outcome,
// trains the predictor, flushes on mispredict and keeps saturating statistics.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEFAULT_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    output logic                   req_ready,
    input  logic                   pred_in,
    input  logic                   res_valid,
    input  logic                   res_taken,
    output logic                   upd_result,
    output logic                   upd_taken,
    output logic                   mispredict,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       branch_cnt,
    output logic [CNT_W-1:0]       mispred_cnt,
    output logic                   err
);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int IW = OW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_max(CNT_W));

    logic          req_d;
    logic          req_acc;
    logic          head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          do_pop;
    logic          do_push;
    logic          flush;
    logic [IW-1:0] inflight;

    // Handshake: a request is taken on any edge where req && req_ready; the
    // slot is reserved at that point so the prediction arriving one cycle
    // later always has room. A req while req_ready is low is dropped (err).
    assign inflight  = {1'b0, occupancy} + IW'(req_d);
    assign req_ready = inflight < IW'(DEPTH);
    assign req_acc   = req && req_ready;

    assign do_pop  = res_valid && !fifo_empty;
    assign flush   = do_pop && (head != res_taken);
    // The capture landing on a flush edge belongs to the wrong path.
    assign do_push = req_d && !flush && !fifo_full;

    bp_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .din       (pred_in),
        .pop       (do_pop),
        .clear     (flush),
        .dout      (head),
        .occupancy (occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d       <= 1'b0;
            upd_result  <= 1'b0;
            upd_taken   <= 1'b0;
            mispredict  <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            err         <= 1'b0;
        end else begin
            req_d      <= req_acc && !flush;
            upd_result <= do_pop;
            upd_taken  <= do_pop && res_taken;
            mispredict <= flush;
            if (do_pop && branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + 1'b1;
            if (flush && mispred_cnt != CNT_MAX) mispred_cnt <= mispred_cnt + 1'b1;
            if ((req && !req_ready) || (res_valid && fifo_empty)) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: training responses are checked by a
// queue-based scoreboard, queue/flag state by inline checks.
module tb_branch_resolve_unit;
    import bp_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int W     = 2 + 2 * CNT_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   req = 1'b0;
    logic                   req_ready;
    logic                   pred_in = 1'b0;
    logic                   res_valid = 1'b0;
    logic                   res_taken = 1'b0;
    logic                   upd_result;
    logic                   upd_taken;
    logic                   mispredict;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0]       branch_cnt;
    logic [CNT_W-1:0]       mispred_cnt;
    logic                   err;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    branch_resolve_unit #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_ready  (req_ready),
        .pred_in    (pred_in),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .upd_result (upd_result),
        .upd_taken  (upd_taken),
        .mispredict (mispredict),
        .occupancy  (occupancy),
        .branch_cnt (branch_cnt),
        .mispred_cnt(mispred_cnt),
        .err        (err)
    );

    // clock/reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic issue_pred(input logic p);
        req = 1'b1;
        tick();
        req     = 1'b0;
        pred_in = p;
        tick();
        pred_in = 1'b0;
    endtask

    task automatic resolve(input logic t, input logic exp_mis, input int eb, input int em);
        res_valid = 1'b1;
        res_taken = t;
        exp_q.push_back({t, exp_mis, CNT_W'(eb), CNT_W'(em)});
        tick();
        res_valid = 1'b0;
        res_taken = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        if (!rst && upd_result) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL upd_unexpected: got upd_result=1 with nothing expected");
            end else begin
                exp_w = exp_q.pop_front();
                check("upd_resp", 32'({upd_taken, mispredict, branch_cnt, mispred_cnt}), 32'(exp_w));
            end
        end
    end

    initial begin
        // reset values
        #12;
        check("rst_occ", 32'(occupancy), 0);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_upd", 32'({upd_result, upd_taken, mispredict}), 0);
        check("rst_err", 32'(err), 0);
        tick();
        rst = 1'b0;
        tick();

        // correct prediction
        issue_pred(1'b1);
        check("t1_occ_before", 32'(occupancy), 1);
        tick();
        resolve(1'b1, 1'b0, 1, 0);
        check("t1_occ_after", 32'(occupancy), 0);
        tick();

        // mispredict flush with a capture pending
        issue_pred(1'b1);
        issue_pred(1'b0);
        issue_pred(1'b1);
        check("t2_occ3", 32'(occupancy), 3);
        req = 1'b1;
        tick();
        req = 1'b0;
        check("t2_ready_reserved", 32'(req_ready), 0);
        pred_in = 1'b1;
        resolve(1'b0, 1'b1, 2, 1);
        pred_in = 1'b0;
        check("t2_occ_flushed", 32'(occupancy), 0);
        check("t2_ready_after", 32'(req_ready), 1);
        tick();
        check("t2_capture_dropped", 32'(occupancy), 0);

        // full / backpressure: predictions 1,0,0,1 back to back
        req = 1'b1;
        tick();
        pred_in = 1'b1;
        tick();
        pred_in = 1'b0;
        tick();
        pred_in = 1'b0;
        tick();
        check("t3_occ3", 32'(occupancy), 3);
        check("t3_ready_low", 32'(req_ready), 0);
        check("t3_err_before", 32'(err), 0);
        pred_in = 1'b1;
        tick();
        req     = 1'b0;
        pred_in = 1'b0;
        check("t3_err_set", 32'(err), 1);
        check("t3_occ_full", 32'(occupancy), 4);
        tick();
        check("t3_occ_stays", 32'(occupancy), 4);

        // simultaneous push/pop, then order check
        resolve(1'b1, 1'b0, 3, 1);
        resolve(1'b0, 1'b0, 4, 1);
        check("t4_occ2", 32'(occupancy), 2);
        req = 1'b1;
        tick();
        req     = 1'b0;
        pred_in = 1'b0;
        resolve(1'b0, 1'b0, 5, 1);
        pred_in = 1'b0;
        check("t4_occ_same", 32'(occupancy), 2);
        resolve(1'b1, 1'b0, 6, 1);
        resolve(1'b0, 1'b0, 7, 1);
        check("t4_occ_empty", 32'(occupancy), 0);
        tick();

        // asynchronous reset with three entries queued
        issue_pred(1'b1);
        issue_pred(1'b0);
        issue_pred(1'b1);
        check("t5_occ3", 32'(occupancy), 3);
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_occ", 32'(occupancy), 0);
        check("t5_rst_ready", 32'(req_ready), 1);
        check("t5_rst_err", 32'(err), 0);
        check("t5_rst_cnts", 32'({branch_cnt, mispred_cnt}), 0);
        check("t5_rst_upd", 32'({upd_result, upd_taken, mispredict}), 0);
        tick();
        rst = 1'b0;
        tick();

        // empty resolve
        res_valid = 1'b1;
        res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        res_taken = 1'b0;
        check("t6_empty_upd", 32'(upd_result), 0);
        check("t6_empty_err", 32'(err), 1);
        check("t6_empty_bcnt", 32'(branch_cnt), 0);
        tick();

        // saturation of a 4-bit counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 1; i <= 17; i++) begin
            issue_pred(1'b1);
            resolve(1'b1, 1'b0, (i > 15) ? 15 : i, 0);
        end
        issue_pred(1'b1);
        resolve(1'b0, 1'b1, 15, 1);
        tick();
        tick();
        check("t7_bcnt_sat", 32'(branch_cnt), 15);
        check("t7_mcnt", 32'(mispred_cnt), 1);
        check("sb_drained", 32'(exp_q.size()), 0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
